// File: rtl/uart_bus_pkg.sv
// Shared definitions for the UART command path bus master.
// The packet decoder uses the same constants in its header handling.
package uart_bus_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BUS,
    REARM
  } bus_state_t;

  localparam int          DEFAULT_TIMEOUT  = 1024;
  localparam logic [31:0] DEFAULT_ERR_DATA = 32'hDEAD_BEEF;

  // A disabled timeout (0) still needs a one-bit counter to keep widths legal.
  function automatic int timer_width(input int timeout);
    return (timeout > 0) ? $clog2(timeout + 1) : 1;
  endfunction

endpackage

// File: rtl/wb_timeout_counter.sv
// Bus-cycle watchdog: counts cycles while enabled and flags the last permitted
// cycle. TIMEOUT = 0 never expires.
module wb_timeout_counter
  import uart_bus_pkg::*;
#(
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int            CW   = timer_width(TIMEOUT);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (TIMEOUT != 0) && !expired) begin
      count <= count + CW'(1);
    end
  end

  assign expired = (TIMEOUT != 0) && (count == LAST);

endmodule

// File: rtl/uart_wb_master.sv
// Single-word Wishbone classic master fed by the UART packet decoder.
//   state | meaning
//   IDLE  | waiting for cpu_start; request latched onto wb_* on start
//   BUS   | cyc/stb asserted, waiting for err, ack or timeout
//   REARM | cycle finished, waiting for the decoder to drop cpu_start
module uart_wb_master
  import uart_bus_pkg::*;
#(
  parameter int            dw       = 32,
  parameter int            aw       = 32,
  parameter int            TIMEOUT  = DEFAULT_TIMEOUT,
  parameter logic [dw-1:0] ERR_DATA = dw'(DEFAULT_ERR_DATA)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cpu_start,
  input  logic          cpu_write,
  input  logic [aw-1:0] cpu_address,
  input  logic [3:0]    cpu_selection,
  input  logic [dw-1:0] cpu_data_wr,
  output logic          cpu_active,
  output logic [dw-1:0] cpu_data_rd,
  output logic          cpu_error,
  output logic [aw-1:0] wb_adr_o,
  output logic [dw-1:0] wb_dat_o,
  output logic [3:0]    wb_sel_o,
  output logic          wb_we_o,
  output logic          wb_cyc_o,
  output logic          wb_stb_o,
  input  logic [dw-1:0] wb_dat_i,
  input  logic          wb_ack_i,
  input  logic          wb_err_i
);

  bus_state_t state, state_nxt;
  logic       load;
  logic       finish;
  logic       fail;
  logic       expired;

  wb_timeout_counter #(
    .TIMEOUT(TIMEOUT)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .clear  (load),
    .enable (state == BUS),
    .expired(expired)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // err outranks ack, ack outranks the watchdog
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    finish    = 1'b0;
    fail      = 1'b0;
    unique case (state)
      IDLE: begin
        if (cpu_start) begin
          load      = 1'b1;
          state_nxt = BUS;
        end
      end
      BUS: begin
        if (wb_err_i || wb_ack_i || expired) begin
          finish    = 1'b1;
          fail      = wb_err_i || !wb_ack_i;
          state_nxt = REARM;
        end
      end
      REARM: begin
        if (!cpu_start) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wb_adr_o    <= '0;
      wb_dat_o    <= '0;
      wb_sel_o    <= '0;
      wb_we_o     <= 1'b0;
      wb_cyc_o    <= 1'b0;
      wb_stb_o    <= 1'b0;
      cpu_active  <= 1'b0;
      cpu_error   <= 1'b0;
      cpu_data_rd <= '0;
    end else begin
      cpu_error <= finish && fail;
      if (load) begin
        wb_adr_o   <= cpu_address;
        wb_dat_o   <= cpu_data_wr;
        wb_sel_o   <= cpu_selection;
        wb_we_o    <= cpu_write;
        wb_cyc_o   <= 1'b1;
        wb_stb_o   <= 1'b1;
        cpu_active <= 1'b1;
      end else if (finish) begin
        wb_cyc_o   <= 1'b0;
        wb_stb_o   <= 1'b0;
        cpu_active <= 1'b0;
        if (!wb_we_o) begin
          cpu_data_rd <= fail ? ERR_DATA : wb_dat_i;
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_wb_master.sv
// Bench for uart_wb_master: transactions are planned up front into per-cycle
// stimulus and expectation tables, then replayed and compared every cycle.
module tb_uart_wb_master;

  localparam int          TO   = 8;
  localparam int          MAXC = 8192;
  localparam int          MAXT = 512;
  localparam logic [31:0] ERRV = 32'hDEAD_BEEF;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_start, cpu_write;
  logic [31:0] cpu_address, cpu_data_wr;
  logic [3:0]  cpu_selection;
  logic        cpu_active, cpu_error;
  logic [31:0] cpu_data_rd;
  logic [31:0] wb_adr_o, wb_dat_o, wb_dat_i;
  logic [3:0]  wb_sel_o;
  logic        wb_we_o, wb_cyc_o, wb_stb_o, wb_ack_i, wb_err_i;

  uart_wb_master #(
    .dw(32), .aw(32), .TIMEOUT(TO), .ERR_DATA(ERRV)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .cpu_start    (cpu_start),
    .cpu_write    (cpu_write),
    .cpu_address  (cpu_address),
    .cpu_selection(cpu_selection),
    .cpu_data_wr  (cpu_data_wr),
    .cpu_active   (cpu_active),
    .cpu_data_rd  (cpu_data_rd),
    .cpu_error    (cpu_error),
    .wb_adr_o     (wb_adr_o),
    .wb_dat_o     (wb_dat_o),
    .wb_sel_o     (wb_sel_o),
    .wb_we_o      (wb_we_o),
    .wb_cyc_o     (wb_cyc_o),
    .wb_stb_o     (wb_stb_o),
    .wb_dat_i     (wb_dat_i),
    .wb_ack_i     (wb_ack_i),
    .wb_err_i     (wb_err_i)
  );

  always #5 clk = ~clk;

  int cyc_n = 0;
  always @(posedge clk) cyc_n <= cyc_n + 1;

  // stimulus per cycle
  logic        d_rst[MAXC], d_start[MAXC], d_we[MAXC], d_ack[MAXC], d_err[MAXC];
  logic [31:0] d_adr[MAXC], d_dat[MAXC], d_rdat[MAXC];
  logic [3:0]  d_sel[MAXC];
  // expected outputs per cycle
  logic        e_stb[MAXC], e_err[MAXC], e_rdu[MAXC], e_zero[MAXC];
  logic [31:0] e_rdv[MAXC];
  int          e_txn[MAXC];
  logic        stb_seen[MAXC];
  // transaction fields
  logic        t_we[MAXT];
  logic [31:0] t_adr[MAXT], t_dat[MAXT];
  logic [3:0]  t_sel[MAXT];

  int          n_txn = 0;
  int          errors = 0;
  int          checks = 0;
  int          end_cyc = 0;
  bit          run = 1'b0;
  logic [31:0] cur_rd = '0;
  int          lit_cyc[$];
  logic [31:0] lit_val[$];

  task automatic chk(input string name, input int k, input logic [31:0] act,
                     input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s cycle=%0d actual=%h required=%h", name, k, act, expv);
    end
  endtask

  // kind: 0 no response, 1 ack, 2 err, 3 ack+err; response arrives w cycles after stb rises.
  // hold: extra cycles the decoder keeps start high beyond seeing active.
  task automatic plan_txn(input int c, input logic we, input logic [31:0] adr,
                          input logic [3:0] sel, input logic [31:0] dat, input int kind,
                          input int w, input logic [31:0] rdat, input int hold,
                          output int nxt, output int len);
    int id, s, idle_at;
    bit got, failed;
    id = n_txn;
    n_txn++;
    t_we[id] = we; t_adr[id] = adr; t_sel[id] = sel; t_dat[id] = dat;
    got    = (kind != 0) && (w < TO);
    failed = got ? (kind >= 2) : 1'b1;
    len    = got ? w + 1 : TO;
    s      = c + 2 + hold;
    for (int k = c; k < s; k++) d_start[k] = 1'b1;
    d_we[c] = we; d_adr[c] = adr; d_sel[c] = sel; d_dat[c] = dat;
    for (int k = c + 1; k <= c + len; k++) begin
      e_stb[k] = 1'b1;
      e_txn[k] = id;
    end
    if (kind != 0) begin
      d_ack[c+1+w]  = (kind % 2) == 1;
      d_err[c+1+w]  = kind >= 2;
      d_rdat[c+1+w] = rdat;
    end
    e_err[c+len+1] = failed;
    if (!we) begin
      e_rdu[c+len+1] = 1'b1;
      e_rdv[c+len+1] = failed ? ERRV : rdat;
    end
    idle_at = (s <= c + len + 1) ? c + len + 2 : s + 1;
    nxt = idle_at;
    if (kind != 0 && c + w + 3 > nxt) nxt = c + w + 3;
  endtask

  // Write with reset asserted during its second strobe cycle.
  task automatic plan_reset_txn(input int c, output int nxt);
    int id;
    id = n_txn;
    n_txn++;
    t_we[id] = 1'b1; t_adr[id] = 32'h2000_0008; t_sel[id] = 4'h3; t_dat[id] = 32'h1357_9BDF;
    d_start[c] = 1'b1; d_start[c+1] = 1'b1;
    d_we[c] = 1'b1; d_adr[c] = 32'h2000_0008; d_sel[c] = 4'h3; d_dat[c] = 32'h1357_9BDF;
    e_stb[c+1] = 1'b1; e_txn[c+1] = id;
    e_stb[c+2] = 1'b1; e_txn[c+2] = id;
    d_rst[c+2] = 1'b1;
    e_rdu[c+3] = 1'b1; e_rdv[c+3] = 32'h0; e_zero[c+3] = 1'b1;
    nxt = c + 4;
  endtask

  task automatic apply(input int k);
    rst           = d_rst[k];
    cpu_start     = d_start[k];
    cpu_write     = d_we[k];
    cpu_address   = d_adr[k];
    cpu_selection = d_sel[k];
    cpu_data_wr   = d_dat[k];
    wb_ack_i      = d_ack[k];
    wb_err_i      = d_err[k];
    wb_dat_i      = d_rdat[k];
  endtask

  function automatic int stb_count(input int a, input int b);
    int n;
    n = 0;
    for (int k = a; k <= b; k++) if (stb_seen[k] === 1'b1) n++;
    return n;
  endfunction

  always @(negedge clk) begin
    if (run && cyc_n >= 1 && cyc_n < end_cyc) begin
      int k;
      k = cyc_n;
      stb_seen[k] = wb_stb_o;
      if (e_rdu[k]) cur_rd = e_rdv[k];
      chk("stb",    k, wb_stb_o,    e_stb[k]);
      chk("cyc",    k, wb_cyc_o,    e_stb[k]);
      chk("active", k, cpu_active,  e_stb[k]);
      chk("error",  k, cpu_error,   e_err[k]);
      chk("rd",     k, cpu_data_rd, cur_rd);
      if (e_stb[k]) begin
        chk("adr", k, wb_adr_o, t_adr[e_txn[k]]);
        chk("dat", k, wb_dat_o, t_dat[e_txn[k]]);
        chk("sel", k, wb_sel_o, t_sel[e_txn[k]]);
        chk("we",  k, wb_we_o,  t_we[e_txn[k]]);
      end
      if (e_zero[k]) begin
        chk("zero_adr", k, wb_adr_o, 32'h0);
        chk("zero_dat", k, wb_dat_o, 32'h0);
        chk("zero_sel", k, wb_sel_o, 32'h0);
        chk("zero_we",  k, wb_we_o,  32'h0);
      end
    end
  end

  initial begin
    int c, nx, len, t1c, t5c, t6c;
    bit we;
    int kind;
    for (int k = 0; k < MAXC; k++) begin
      d_rst[k] = 1'b0; d_start[k] = 1'b0; d_ack[k] = 1'b0; d_err[k] = 1'b0;
      d_we[k] = 1'($urandom); d_adr[k] = $urandom; d_dat[k] = $urandom;
      d_sel[k] = 4'($urandom); d_rdat[k] = $urandom;
      e_stb[k] = 1'b0; e_err[k] = 1'b0; e_rdu[k] = 1'b0; e_zero[k] = 1'b0;
      e_rdv[k] = '0; e_txn[k] = 0; stb_seen[k] = 1'b0;
    end
    for (int k = 0; k < 3; k++) d_rst[k] = 1'b1;
    for (int k = 1; k <= 3; k++) e_zero[k] = 1'b1;

    c = 5;
    t1c = c;
    plan_txn(c, 1'b1, 32'h1000_0004, 4'hF, 32'hA5A5_1234, 1, 2, 32'h0, 0, nx, len);
    chk("model_wr_len", c, len, 3);
    c = nx + 1;
    plan_txn(c, 1'b0, 32'h0000_0010, 4'hF, 32'h0, 1, 0, 32'hCAFE_F00D, 0, nx, len);
    chk("model_rd_len", c, len, 1);
    lit_cyc.push_back(c + len + 1); lit_val.push_back(32'hCAFE_F00D);
    c = nx;
    plan_txn(c, 1'b1, 32'h0000_0020, 4'h5, 32'h7777_8888, 1, 0, 32'h9999_0000, 0, nx, len);
    lit_cyc.push_back(c + len + 1); lit_val.push_back(32'hCAFE_F00D);
    c = nx + 2;
    plan_txn(c, 1'b0, 32'h0000_0044, 4'h1, 32'h0, 3, 1, 32'h1111_2222, 0, nx, len);
    lit_cyc.push_back(c + len + 1); lit_val.push_back(32'hDEAD_BEEF);
    c = nx;
    t5c = c;
    plan_txn(c, 1'b0, 32'h0000_0080, 4'hF, 32'h0, 1, 9, 32'h5555_AAAA, 0, nx, len);
    chk("model_to_len", c, len, 8);
    lit_cyc.push_back(c + len + 1); lit_val.push_back(32'hDEAD_BEEF);
    c = nx;
    t6c = c;
    plan_txn(c, 1'b0, 32'h0000_00C0, 4'hC, 32'h0, 1, 0, 32'h0BAD_CAFE, 7, nx, len);
    c = nx;
    plan_txn(c, 1'b1, 32'h0000_00C4, 4'hF, 32'h1234_5678, 1, 1, 32'h0, 0, nx, len);
    c = nx + 1;
    plan_reset_txn(c, nx);
    c = nx;
    plan_txn(c, 1'b0, 32'h0000_0100, 4'hF, 32'h0, 1, 3, 32'h600D_F00D, 0, nx, len);
    lit_cyc.push_back(c + len + 1); lit_val.push_back(32'h600D_F00D);
    c = nx;

    for (int i = 0; i < 150 && c < MAXC - 100; i++) begin
      we = 1'($urandom);
      kind = $urandom_range(0, 9);
      kind = (kind <= 6) ? 1 : (kind <= 8) ? 2 : 0;
      plan_txn(c, we, $urandom, 4'($urandom), $urandom, kind, $urandom_range(0, 11),
               $urandom, $urandom_range(0, 3), nx, len);
      c = nx + $urandom_range(0, 2);
    end
    end_cyc = c + 5;
    run = 1'b1;

    apply(0);
    for (int k = 1; k < end_cyc; k++) begin
      @(posedge clk);
      #1;
      apply(cyc_n);
      while (lit_cyc.size() > 0 && lit_cyc[0] <= cyc_n) begin
        chk("lit_rd", cyc_n, cpu_data_rd, lit_val[0]);
        void'(lit_cyc.pop_front());
        void'(lit_val.pop_front());
      end
    end

    chk("stb_cycles_write", t1c, stb_count(t1c, t1c + 6), 3);
    chk("stb_cycles_timeout", t5c, stb_count(t5c, t5c + 12), 8);
    chk("stb_cycles_held_start", t6c, stb_count(t6c, t6c + 10), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
